fetch_queue_4w: RTL and testbench



---
 rtl/fetch_queue_4w_pkg.sv | 23 ++
 rtl/fetch_queue_4w_compact4.sv | 34 +++
 rtl/fetch_queue_4w.sv | 160 ++++++++++++++++
 tb/tb_fetch_queue_4w.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_4w_pkg.sv
// ---------------------------------------------------------------------------
// fetch_queue_4w_pkg : shared frontend types for the 4-wide fetch queue
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_queue_4w_pkg;

  localparam int unsigned NR_ISSUE = 4;

  typedef struct packed {
    logic [63:0] address;
    logic [31:0] instruction;
    logic        bp_valid;
    logic        bp_taken;
    logic [63:0] bp_target;
    logic        ex_valid;
    logic [63:0] ex_cause;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue_4w_compact4.sv
// ---------------------------------------------------------------------------
// fq_compact4 : packs the valid slots of a fetch group into a dense vector
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fq_compact4
  import fetch_queue_4w_pkg::*;
(
  input  logic [NR_ISSUE-1:0] in_valid_i,
  input  fetch_entry_t        in_entry_i [NR_ISSUE],
  output fetch_entry_t        dense_o    [NR_ISSUE],
  output logic [2:0]          npush_o
);

  always_comb begin
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 0; k < NR_ISSUE; k++) begin
      dense_o[k] = '0;
    end
    // Slot order is preserved: each valid slot lands at the next free dense position.
    for (int k = 0; k < NR_ISSUE; k++) begin
      if (in_valid_i[k]) begin
        dense_o[idx[1:0]] = in_entry_i[k];
        idx               = idx + 3'd1;
      end
    end
    npush_o = idx;
  end

endmodule

`default_nettype wire

// File: rtl/fetch_queue_4w.sv
// ---------------------------------------------------------------------------
// fetch_queue_4w : 4-wide in-order instruction queue between frontend and id_stage
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_queue_4w
  import fetch_queue_4w_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned NR_WIDTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic [3:0]                 in_valid_i,
  input  fetch_entry_t               in_entry_i_0,
  input  fetch_entry_t               in_entry_i_1,
  input  fetch_entry_t               in_entry_i_2,
  input  fetch_entry_t               in_entry_i_3,
  output logic                       in_ready_o,
  output fetch_entry_t               fetch_entry_o_0,
  output fetch_entry_t               fetch_entry_o_1,
  output fetch_entry_t               fetch_entry_o_2,
  output fetch_entry_t               fetch_entry_o_3,
  output logic                       fetch_entry_valid_o_0,
  output logic                       fetch_entry_valid_o_1,
  output logic                       fetch_entry_valid_o_2,
  output logic                       fetch_entry_valid_o_3,
  input  logic                       decoded_instr_ack_i_0,
  input  logic                       decoded_instr_ack_i_1,
  input  logic                       decoded_instr_ack_i_2,
  input  logic                       decoded_instr_ack_i_3,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] read_ptr_q, read_ptr_d;
  logic [PTR_W-1:0] write_ptr_q, write_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  fetch_entry_t in_entry [NR_ISSUE];
  fetch_entry_t dense    [NR_ISSUE];
  fetch_entry_t head     [NR_ISSUE];
  logic [3:0]   out_valid;
  logic [3:0]   ack;
  logic [3:0]   ack_eff;
  logic [2:0]   npush;
  logic [2:0]   npush_eff;
  logic [2:0]   npop;

  assign in_entry[0] = in_entry_i_0;
  assign in_entry[1] = in_entry_i_1;
  assign in_entry[2] = in_entry_i_2;
  assign in_entry[3] = in_entry_i_3;

  fq_compact4 u_compact (
    .in_valid_i (in_valid_i),
    .in_entry_i (in_entry),
    .dense_o    (dense),
    .npush_o    (npush)
  );

  // Ready only when a whole group is guaranteed to fit, independent of this cycle's pops.
  assign in_ready_o = (count_q <= CNT_W'(DEPTH - 4));
  assign npush_eff  = in_ready_o ? npush : 3'd0;

  for (genvar k = 0; k < NR_ISSUE; k++) begin : g_slot
    assign out_valid[k] = (count_q > CNT_W'(k));
    assign head[k]      = mem_q[read_ptr_q + PTR_W'(k)];
  end

  assign fetch_entry_o_0       = head[0];
  assign fetch_entry_o_1       = head[1];
  assign fetch_entry_o_2       = head[2];
  assign fetch_entry_o_3       = head[3];
  assign fetch_entry_valid_o_0 = out_valid[0];
  assign fetch_entry_valid_o_1 = out_valid[1];
  assign fetch_entry_valid_o_2 = out_valid[2];
  assign fetch_entry_valid_o_3 = out_valid[3];
  assign count_o               = count_q;

  assign ack     = {decoded_instr_ack_i_3, decoded_instr_ack_i_2,
                    decoded_instr_ack_i_1, decoded_instr_ack_i_0};
  assign ack_eff = ack & out_valid;

  // Only the unbroken run of acks starting at the head retires entries.
  always_comb begin
    npop = 3'd0;
    if (ack_eff[0]) begin
      npop = 3'd1;
      if (ack_eff[1]) begin
        npop = 3'd2;
        if (ack_eff[2]) begin
          npop = 3'd3;
          if (ack_eff[3]) begin
            npop = 3'd4;
          end
        end
      end
    end
  end

  always_comb begin
    mem_d       = mem_q;
    read_ptr_d  = read_ptr_q;
    write_ptr_d = write_ptr_q;
    count_d     = count_q;
    if (flush_i) begin
      read_ptr_d  = '0;
      write_ptr_d = '0;
      count_d     = '0;
    end else begin
      for (int k = 0; k < NR_ISSUE; k++) begin
        if (3'(k) < npush_eff) begin
          mem_d[write_ptr_q + PTR_W'(k)] = dense[k];
        end
      end
      read_ptr_d  = read_ptr_q + PTR_W'(npop);
      write_ptr_d = write_ptr_q + PTR_W'(npush_eff);
      count_d     = count_q + CNT_W'(npush_eff) - CNT_W'(npop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      read_ptr_q  <= '0;
      write_ptr_q <= '0;
      count_q     <= '0;
    end else begin
      read_ptr_q  <= read_ptr_d;
      write_ptr_q <= write_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (count_q <= CNT_W'(DEPTH));
      assert ((DEPTH >= 8) && ((DEPTH & (DEPTH - 1)) == 0));
      assert (NR_WIDTH == NR_ISSUE);
      for (int k = 0; k < NR_ISSUE; k++) begin
        assert (!(ack[k] && !out_valid[k]));
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue_4w.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue_4w : directed and random checks of fetch_queue_4w against a queue model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_queue_4w;
  import fetch_queue_4w_pkg::*;

  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic         flush = 1'b0;
  logic [3:0]   in_valid = 4'b0;
  logic [3:0]   ack = 4'b0;
  fetch_entry_t in_e  [4];
  fetch_entry_t out_e [4];
  logic [3:0]   out_v;
  logic         in_ready;
  logic [4:0]   count;

  fetch_entry_t mq[$];
  int           total = 0;
  int           bad = 0;
  bit           check_en = 1'b0;
  logic [63:0]  next_addr = 64'h1000;

  always #5 clk = ~clk;

  fetch_queue_4w #(.DEPTH(DEPTH), .NR_WIDTH(4)) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_ni),
    .flush_i               (flush),
    .in_valid_i            (in_valid),
    .in_entry_i_0          (in_e[0]),
    .in_entry_i_1          (in_e[1]),
    .in_entry_i_2          (in_e[2]),
    .in_entry_i_3          (in_e[3]),
    .in_ready_o            (in_ready),
    .fetch_entry_o_0       (out_e[0]),
    .fetch_entry_o_1       (out_e[1]),
    .fetch_entry_o_2       (out_e[2]),
    .fetch_entry_o_3       (out_e[3]),
    .fetch_entry_valid_o_0 (out_v[0]),
    .fetch_entry_valid_o_1 (out_v[1]),
    .fetch_entry_valid_o_2 (out_v[2]),
    .fetch_entry_valid_o_3 (out_v[3]),
    .decoded_instr_ack_i_0 (ack[0]),
    .decoded_instr_ack_i_1 (ack[1]),
    .decoded_instr_ack_i_2 (ack[2]),
    .decoded_instr_ack_i_3 (ack[3]),
    .count_o               (count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_entry(input string name, input fetch_entry_t act, input fetch_entry_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got addr %0h expected addr %0h (got %0h expected %0h)",
               name, act.address, exp.address, act, exp);
    end
  endtask

  function automatic fetch_entry_t mk(input logic [63:0] addr);
    fetch_entry_t e;
    e.address     = addr;
    e.instruction = $urandom;
    e.bp_valid    = 1'($urandom);
    e.bp_taken    = 1'($urandom);
    e.bp_target   = {$urandom, $urandom};
    e.ex_valid    = 1'($urandom);
    e.ex_cause    = {$urandom, $urandom};
    return e;
  endfunction

  task automatic new_group();
    for (int k = 0; k < 4; k++) begin
      in_e[k]   = mk(next_addr);
      next_addr = next_addr + 64'd4;
    end
  endtask

  // Reference model: an ordered list of the entries the queue must hold.
  always @(posedge clk) begin
    if (!rst_ni || flush) begin
      mq.delete();
    end else begin
      automatic bit room = (DEPTH - mq.size() >= 4);
      automatic int np = 0;
      while (np < 4 && np < mq.size() && ack[np]) np++;
      repeat (np) void'(mq.pop_front());
      if (room) begin
        for (int k = 0; k < 4; k++) begin
          if (in_valid[k]) mq.push_back(in_e[k]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("count", 64'(count), 64'(mq.size()));
      chk("in_ready", 64'(in_ready), 64'(DEPTH - mq.size() >= 4));
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("valid%0d", k), 64'(out_v[k]), 64'(k < mq.size()));
        if (k < mq.size()) chk_entry($sformatf("entry%0d", k), out_e[k], mq[k]);
      end
    end
  end

  task automatic cyc(input logic [3:0] v, input logic [3:0] a, input bit f);
    in_valid = v;
    ack      = a;
    flush    = f;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  function automatic logic [3:0] valid_mask();
    logic [3:0] m;
    for (int k = 0; k < 4; k++) m[k] = (k < mq.size());
    return m;
  endfunction

  initial begin
    logic [63:0] first_addr;
    logic [63:0] pin_addr;
    for (int k = 0; k < 4; k++) in_e[k] = '0;

    rst_ni = 1'b0;
    cyc(4'b0, 4'b0, 1'b0);
    cyc(4'b0, 4'b0, 1'b0);
    rst_ni   = 1'b1;
    check_en = 1'b1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_valids", 64'(out_v), 64'd0);
    cyc(4'b0, 4'b0, 1'b0);
    cyc(4'b0, 4'b0, 1'b0);
    chk("idle_count", 64'(count), 64'd0);

    // Sparse mask: slots 0 and 2 valid.
    in_e[0] = mk(64'h104);
    in_e[1] = mk(64'h200);
    in_e[2] = mk(64'h10C);
    in_e[3] = mk(64'h300);
    cyc(4'b0101, 4'b0, 1'b0);
    chk("sparse_count", 64'(count), 64'd2);
    chk("sparse_head", out_e[0].address, 64'h104);
    chk("sparse_slot1", out_e[1].address, 64'h10C);
    chk("sparse_v2v3", 64'(out_v[3:2]), 64'd0);
    cyc(4'b0, 4'b0, 1'b1);
    chk("flush_count", 64'(count), 64'd0);

    // Fill to full, then a dropped group.
    new_group();
    first_addr = in_e[0].address;
    cyc(4'b1111, 4'b0, 1'b0);
    repeat (3) begin
      new_group();
      cyc(4'b1111, 4'b0, 1'b0);
    end
    chk("full_count", 64'(count), 64'd16);
    chk("full_ready", 64'(in_ready), 64'd0);
    new_group();
    cyc(4'b1111, 4'b0, 1'b0);
    chk("drop_count", 64'(count), 64'd16);
    chk("drop_head", out_e[0].address, first_addr);

    // Walk read_ptr to 14 with count 4, then push 4 while popping 2 across the wrap.
    cyc(4'b0, 4'b1111, 1'b0);
    cyc(4'b0, 4'b1111, 1'b0);
    cyc(4'b0, 4'b1111, 1'b0);
    cyc(4'b0, 4'b0011, 1'b0);
    new_group();
    pin_addr = in_e[0].address;
    cyc(4'b0011, 4'b0, 1'b0);
    chk("pre_wrap_count", 64'(count), 64'd4);
    new_group();
    cyc(4'b1111, 4'b0011, 1'b0);
    chk("wrap_count", 64'(count), 64'd6);
    chk("wrap_head", out_e[0].address, pin_addr);
    cyc(4'b0, 4'b1110, 1'b0);
    chk("ack0111_count", 64'(count), 64'd6);
    chk("ack0111_head", out_e[0].address, pin_addr);

    // Flush racing a push and a full ack.
    new_group();
    cyc(4'b0111, 4'b0, 1'b0);
    chk("nine_count", 64'(count), 64'd9);
    new_group();
    cyc(4'b1111, 4'b1111, 1'b1);
    chk("flushrace_count", 64'(count), 64'd0);
    chk("flushrace_valids", 64'(out_v), 64'd0);
    chk("flushrace_ready", 64'(in_ready), 64'd1);
    new_group();
    pin_addr = in_e[3].address;
    cyc(4'b1000, 4'b0, 1'b0);
    chk("post_flush_head", out_e[0].address, pin_addr);

    // Randomised traffic with occasional flushes and resets.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] a;
      new_group();
      a = ((i / 300) % 2 == 0) ? 4'($urandom & $urandom) : 4'($urandom | $urandom);
      rst_ni = !((i == 500) || ($urandom_range(0, 199) == 0));
      cyc(4'($urandom), a & valid_mask(), ($urandom_range(0, 59) == 0));
      if (i == 500) begin
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_valids", 64'(out_v), 64'd0);
      end
    end
    rst_ni = 1'b1;
    cyc(4'b0, 4'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
